// File: rtl/fc_argmax_drain.sv
// ---------------------------------------------------------------------------
// fc_argmax_drain
//
// Output end of the conv->fc pipeline. Accepts one vector of N_CLASS signed
// fc logits over a valid/ready handshake, scans the captured copy one logit
// per cycle, and presents the winning class index plus its logit over a
// second valid/ready handshake. Only one vector is in flight at a time.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         synchronous, active-high reset
//   i_pre_valid   logit vector valid (from fc o_post_valid)
//   o_pre_ready   ready to accept a vector (only in IDLE, low during reset)
//   i_res         packed logit vector, class k at [k*DATA_W +: DATA_W]
//   o_post_valid  result valid, held until accepted
//   i_post_ready  downstream ready for the result
//   o_class       argmax index (lowest index wins ties)
//   o_max         logit of o_class
//   o_busy        high while scanning or holding a result
// ---------------------------------------------------------------------------
module fc_argmax_drain #(
    parameter int N_CLASS = 10,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_pre_valid,
    output logic                        o_pre_ready,
    input  logic [N_CLASS*DATA_W-1:0]   i_res,
    output logic                        o_post_valid,
    input  logic                        i_post_ready,
    output logic [IDX_W-1:0]            o_class,
    output logic [DATA_W-1:0]           o_max,
    output logic                        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          cnt;
    logic signed [DATA_W-1:0]  logit_buf [N_CLASS];
    logic signed [DATA_W-1:0]  best_val;
    logic [IDX_W-1:0]          best_idx;

    logic                      in_fire;
    logic                      out_fire;
    logic signed [DATA_W-1:0]  cand_val;
    logic                      take;
    logic signed [DATA_W-1:0]  nxt_val;
    logic [IDX_W-1:0]          nxt_idx;
    logic                      last;

    // Strict signed greater-than: an equal candidate never displaces the
    // incumbent, so ties resolve to the lower class index.
    function automatic logic gt_signed(input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
        return a > b;
    endfunction

    // Handshakes. Ready is held low while reset is asserted so nothing is
    // accepted into a machine that is being cleared.
    assign o_pre_ready = (state == ST_IDLE) && !i_rst;
    assign in_fire     = i_pre_valid && o_pre_ready;
    assign out_fire    = o_post_valid && i_post_ready;
    assign o_busy      = (state == ST_SCAN) || (state == ST_DONE);

    // Scan step: compare the current buffered logit against the running best.
    assign cand_val = logit_buf[cnt];
    assign take     = gt_signed(cand_val, best_val);
    assign nxt_val  = take ? cand_val : best_val;
    assign nxt_idx  = take ? cnt : best_idx;
    assign last     = (cnt == IDX_W'(N_CLASS - 1));

    // Logit capture: the buffer only loads on an accepted vector, so input
    // changes after the handshake (or while valid is low) have no effect.
    always_ff @(posedge i_clk) begin
        if (in_fire) begin
            for (int k = 0; k < N_CLASS; k++) begin
                logit_buf[k] <= i_res[k*DATA_W +: DATA_W];
            end
        end
    end

    // Control FSM with registered result outputs. best_val/best_idx are data
    // and are always seeded on acceptance, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            o_post_valid <= 1'b0;
            o_class      <= '0;
            o_max        <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        best_val <= i_res[DATA_W-1:0];
                        best_idx <= '0;
                        cnt      <= IDX_W'(1);
                        if (N_CLASS == 1) begin
                            // Single class: nothing to scan, the result is known.
                            state        <= ST_DONE;
                            o_post_valid <= 1'b1;
                            o_class      <= '0;
                            o_max        <= i_res[DATA_W-1:0];
                        end else begin
                            state <= ST_SCAN;
                        end
                    end
                end

                ST_SCAN: begin
                    best_val <= nxt_val;
                    best_idx <= nxt_idx;
                    if (last) begin
                        // Load the result with the outcome of the final compare.
                        state        <= ST_DONE;
                        o_post_valid <= 1'b1;
                        o_class      <= nxt_idx;
                        o_max        <= nxt_val;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end

                ST_DONE: begin
                    // Result holds until taken; o_class/o_max keep their value
                    // after the handshake until the next result is loaded.
                    if (out_fire) begin
                        state        <= ST_IDLE;
                        o_post_valid <= 1'b0;
                        cnt          <= '0;
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    o_post_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
